div_unit: RTL and testbench

Iterative 32-bit integer divider serving the EX stage over the `ex_div` handshake; this block is the slave end, EX is the master. It latches operands on `start`, runs a radix-2 restoring division for a fixed 32 iterations, applies sign fix-up and returns quotient and remainder together with a one-cycle `done` pulse. It covers LoongArch `div.w`, `mod.w`, `div.wu` and `mod.wu`. EX chooses quotient or remainder itself.

---
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider for the EX stage.
// Latches operand magnitudes on start, runs 32 fixed iterations, applies
// sign fix-up and returns quotient and remainder with a one-cycle done.
module div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic [1:0]  op,
   input  logic        start,
   input  logic        cancel,
   output logic        is_running,
   output logic [31:0] quotient_out,
   output logic [31:0] remainder_out,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t      state, state_nxt;
   logic [31:0] dvd_q;       // dividend shifts out, quotient bits shift in
   logic [31:0] dvs_q;       // divisor magnitude
   logic [32:0] prem_q;      // partial remainder
   logic [4:0]  cnt_q;
   logic        q_neg_q, r_neg_q;

   logic        signed_op;
   logic [31:0] abs_dvd, abs_dvs;
   logic [33:0] trial;
   logic        q_bit;
   logic [32:0] prem_nxt;
   logic [31:0] dvd_nxt;
   logic [31:0] q_fix, r_fix;
   logic        load, iterate, fire;

   // op[0] picks quotient vs remainder in EX; both are always returned here
   logic        unused_op0;
   assign unused_op0 = op[0];

   // Operand magnitudes; 0x80000000 negates to itself, which is the
   // correct unsigned magnitude.
   always_comb begin
      signed_op = ~op[1];
      abs_dvd   = (signed_op && dividend[31]) ? -dividend : dividend;
      abs_dvs   = (signed_op && divisor[31])  ? -divisor  : divisor;
   end

   // One restoring step: shift {prem, dvd} left, trial-subtract divisor.
   // Top bit of the 34-bit trial is the borrow, i.e. "result negative".
   always_comb begin
      trial    = {prem_q, dvd_q[31]} - {2'b00, dvs_q};
      q_bit    = ~trial[33];
      prem_nxt = q_bit ? trial[32:0] : {prem_q[31:0], dvd_q[31]};
      dvd_nxt  = {dvd_q[30:0], q_bit};
   end

   // Sign fix-up of the magnitude results
   always_comb begin
      q_fix = q_neg_q ? -dvd_q : dvd_q;
      r_fix = r_neg_q ? -prem_q[31:0] : prem_q[31:0];
   end

   // Next-state and control strobes; cancel always wins
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      iterate   = 1'b0;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            if (start && !cancel) begin
               state_nxt = CALC;
               load      = 1'b1;
            end
         end
         CALC: begin
            if (cancel) begin
               state_nxt = IDLE;
            end else begin
               iterate = 1'b1;
               if (cnt_q == 5'd31) state_nxt = FINISH;
            end
         end
         FINISH: begin
            state_nxt = IDLE;
            fire      = ~cancel;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Datapath registers: load on accept, iterate in CALC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (load) begin
         dvd_q   <= abs_dvd;
         dvs_q   <= abs_dvs;
         prem_q  <= '0;
         cnt_q   <= '0;
         q_neg_q <= signed_op & (dividend[31] ^ divisor[31]);
         r_neg_q <= signed_op & dividend[31];
      end else if (iterate) begin
         dvd_q   <= dvd_nxt;
         prem_q  <= prem_nxt;
         cnt_q   <= cnt_q + 5'd1;
      end
   end

   // Result registers and done pulse; results hold until next completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done          <= 1'b0;
         quotient_out  <= '0;
         remainder_out <= '0;
      end else begin
         done <= fire;
         if (fire) begin
            quotient_out  <= q_fix;
            remainder_out <= r_fix;
         end
      end
   end

   assign is_running = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed literal cases plus randomized traffic against a
// transaction-level model (result = arithmetic division, 34 cycles later).
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] dividend = '0, divisor = '0;
   logic [1:0]  op = 2'b00;
   logic        start = 1'b0, cancel = 1'b0;
   logic        is_running, done;
   logic [31:0] quotient_out, remainder_out;

   int checks = 0;
   int failures = 0;

   div_unit dut (
      .clk(clk), .rst_n(rst_n), .dividend(dividend), .divisor(divisor),
      .op(op), .start(start), .cancel(cancel), .is_running(is_running),
      .quotient_out(quotient_out), .remainder_out(remainder_out), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Arithmetic reference: {quotient, remainder}
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] o);
      int sa, sb;
      if (o[1]) begin
         if (b == 0) return {32'hFFFF_FFFF, a};
         return {a / b, a % b};
      end
      if (b == 0) return {(a[31] ? 32'd1 : 32'hFFFF_FFFF), a};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      sa = a;
      sb = b;
      return {32'(sa / sb), 32'(sa % sb)};
   endfunction

   // Transaction model: cycles left until done (0 = idle)
   int          remaining = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_q = '0, m_r = '0, pend_q = '0, pend_r = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= 0;
         m_done    <= 1'b0;
         m_q       <= '0;
         m_r       <= '0;
      end else begin
         m_done <= 1'b0;
         if (remaining == 0) begin
            if (start && !cancel) begin
               {pend_q, pend_r} <= ref_div(dividend, divisor, op);
               remaining        <= 33;
            end
         end else if (cancel) begin
            remaining <= 0;
         end else begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
               m_done <= 1'b1;
               m_q    <= pend_q;
               m_r    <= pend_r;
            end
         end
      end
   end

   // Every-cycle compare against the model
   always @(negedge clk) begin
      chk("running", {31'd0, is_running}, {31'd0, remaining != 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("quotient", quotient_out, m_q);
      chk("remainder", remainder_out, m_r);
   end

   // Start in cycle 0; returns at cycle 1 (just after the accepting edge)
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
      @(posedge clk); #1;
      dividend = a; divisor = b; op = o; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Count negedges from the current cycle until done (bounded)
   task automatic wait_done(output int lat);
      lat = 0;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] o, input logic [31:0] eq, input logic [31:0] er);
      int lat;
      logic [31:0] mq, mr;
      issue(a, b, o);
      wait_done(lat);
      chk({nm, " latency"}, lat, 34);
      chk({nm, " q"}, quotient_out, eq);
      chk({nm, " r"}, remainder_out, er);
      {mq, mr} = ref_div(a, b, o);
      chk({nm, " model q"}, mq, eq);
      chk({nm, " model r"}, mr, er);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] sp [4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
      case ($urandom % 5)
         0: return sp[$urandom % 4];
         1: return ($urandom % 2) ? 32'($urandom % 20) : -32'($urandom % 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      bit seen;
      // reset state
      #2;
      chk("reset running", {31'd0, is_running}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset q", quotient_out, 32'd0);
      chk("reset r", remainder_out, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 100/7 unsigned with explicit per-cycle timeline
      issue(32'd100, 32'd7, 2'b10);
      for (int n = 1; n <= 33; n++) begin
         @(negedge clk);
         chk("t1 running", {31'd0, is_running}, 32'd1);
         chk("t1 no done", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      chk("t1 done", {31'd0, done}, 32'd1);
      chk("t1 idle", {31'd0, is_running}, 32'd0);
      chk("t1 q", quotient_out, 32'd14);
      chk("t1 r", remainder_out, 32'd2);
      @(negedge clk);
      chk("t1 done drop", {31'd0, done}, 32'd0);

      directed("s -7/2", -32'd7, 32'd2, 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      directed("s 7/-2", 32'd7, -32'd2, 2'b00, 32'hFFFF_FFFD, 32'd1);
      directed("s -7/-2", -32'd7, -32'd2, 2'b00, 32'd3, 32'hFFFF_FFFF);
      directed("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 32'd0);
      directed("u big", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'd0, 32'h8000_0000);
      directed("u div0", 32'h1234, 32'd0, 2'b11, 32'hFFFF_FFFF, 32'h1234);
      directed("s div0", -32'd5, 32'd0, 2'b01, 32'd1, 32'hFFFF_FFFB);

      // cancel in cycle 10: no done, previous results held
      issue(32'd100, 32'd7, 2'b10);
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
      @(negedge clk);
      chk("cancel idle", {31'd0, is_running}, 32'd0);
      chk("cancel q held", quotient_out, 32'd1);
      chk("cancel r held", remainder_out, 32'hFFFF_FFFB);
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("cancel no done", {31'd0, seen}, 32'd0);

      // start+cancel together in IDLE: nothing accepted
      @(posedge clk); #1 start = 1'b1; cancel = 1'b1;
      @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
      @(negedge clk);
      chk("start+cancel idle", {31'd0, is_running}, 32'd0);

      // start with new operands in cycle 5 is ignored
      issue(32'd200, 32'd9, 2'b10);
      repeat (4) @(posedge clk);
      #1 start = 1'b1; dividend = 32'd7; divisor = 32'd1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(lat);
      chk("ignored latency", lat, 29);
      chk("ignored q", quotient_out, 32'd22);
      chk("ignored r", remainder_out, 32'd2);

      // back-to-back: start in the done cycle
      issue(32'd50, 32'd5, 2'b10);
      wait_done(lat);
      chk("b2b first q", quotient_out, 32'd10);
      dividend = 32'd1003; divisor = 32'd10; op = 2'b10; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(lat);
      chk("b2b latency", lat, 34);
      chk("b2b q", quotient_out, 32'd100);
      chk("b2b r", remainder_out, 32'd3);

      // reset in cycle 20
      issue(32'd100, 32'd7, 2'b10);
      repeat (19) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid rst running", {31'd0, is_running}, 32'd0);
      chk("mid rst done", {31'd0, done}, 32'd0);
      chk("mid rst q", quotient_out, 32'd0);
      chk("mid rst r", remainder_out, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      directed("after rst 9/3", 32'd9, 32'd3, 2'b00, 32'd3, 32'd0);

      // randomized traffic, checked by the every-cycle compare
      for (int t = 0; t < 60; t++) begin
         int cc;
         cc = ($urandom % 6 == 0) ? int'($urandom_range(1, 33)) : 0;
         issue(pick(), pick(), 2'($urandom));
         for (int cyc = 1; cyc <= 34; cyc++) begin
            cancel = (cyc == cc);
            if (cyc >= 2 && cyc <= 32 && $urandom % 4 == 0) begin
               start = 1'b1; dividend = $urandom; divisor = $urandom; op = 2'($urandom);
            end else begin
               start = 1'b0;
            end
            @(posedge clk); #1;
         end
         start = 1'b0; cancel = 1'b0;
      end
      repeat (40) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
